switch_conf_ctrl: RTL

SWITCH_CONF_CTRL -- requirements
Module: switch_conf_ctrl

---
 rtl/switch_conf_ctrl_pkg.sv | 18 +
 rtl/switch_conf_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/switch_conf_ctrl_pkg.sv
// Shared sizing defaults, FSM state encoding and the "output off" code for the
// switch configuration controller.
package switch_conf_ctrl_pkg;

  localparam int DEF_NUM_OUT = 8;
  localparam int DEF_CONF_W  = 4;

  // Select code 0 turns a switch output off.
  localparam int CODE_OFF = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/switch_conf_ctrl.sv
// Collects a frame of per-output select codes into a shadow bank and commits
// the whole bank to conf_out atomically once the datapath reports idle.
module switch_conf_ctrl
  import switch_conf_ctrl_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int CONF_W  = DEF_CONF_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_start,
  input  logic [CONF_W-1:0]         cfg_data,
  input  logic                      cfg_clear,
  input  logic                      dp_idle,
  output logic [NUM_OUT*CONF_W-1:0] conf_out,
  output logic                      conf_loaded,
  output logic                      cfg_done,
  output logic                      cfg_err
);

  localparam int                 IDX_W    = $clog2(NUM_OUT) + 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OUT - 1);
  localparam logic [CONF_W-1:0]  OFF      = CONF_W'(CODE_OFF);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CONF_W-1:0]         shadow_q [NUM_OUT];
  logic [CONF_W-1:0]         shadow_d [NUM_OUT];
  logic [NUM_OUT*CONF_W-1:0] conf_q, conf_d;
  logic                      loaded_q, loaded_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      beat;

  assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign beat        = cfg_valid && cfg_ready;
  assign conf_out    = conf_q;
  assign conf_loaded = loaded_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    conf_d   = conf_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (cfg_clear) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      loaded_d = 1'b0;
      conf_d   = '0;
      for (int i = 0; i < NUM_OUT; i++) shadow_d[i] = OFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat) begin
            if (cfg_start) begin
              shadow_d[0] = cfg_data;
              idx_d       = IDX_W'(1);
              state_d     = (NUM_OUT == 1) ? ST_WAIT : ST_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            if (cfg_start) begin
              // A new start mid-frame restarts collection from output 0.
              shadow_d[0] = cfg_data;
              idx_d       = IDX_W'(1);
              err_d       = 1'b1;
            end else begin
              for (int i = 0; i < NUM_OUT; i++) begin
                if (idx_q == IDX_W'(i)) shadow_d[i] = cfg_data;
              end
              idx_d = idx_q + IDX_W'(1);
              if (idx_q == LAST_IDX) state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dp_idle) begin
            for (int i = 0; i < NUM_OUT; i++) conf_d[i*CONF_W +: CONF_W] = shadow_q[i];
            idx_d    = '0;
            loaded_d = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_COMMIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      conf_q   <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) shadow_q[i] <= OFF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      conf_q   <= conf_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_OUT; i++) shadow_q[i] <= shadow_d[i];
    end
  end

endmodule
